// File: rtl/mult6_pkg.sv
// Shared types and constants for the shared 6x6 multiplier scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mult6_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default configuration
  localparam int W_DEF    = 6;
  localparam int NREQ_DEF = 4;

  // Full product width for a W x W unsigned multiply
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult6_csa_core.sv
// Combinational W x W unsigned multiplier; partial products reduced with carry-save adders.
// Latency: purely combinational, result valid in the same cycle as the operands.
// Backpressure: none; the scheduler decides when the output is registered.
module mult6_csa_core
  import mult6_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int PW = prod_w(W);

  logic [PW-1:0] s;
  logic [PW-1:0] c;
  logic [PW-1:0] pp;
  logic [PW-1:0] ns;
  logic [PW-1:0] nc;

  // Accumulate one shifted partial product per row into a redundant sum/carry pair.
  // Carries out of the top bit are always zero because the product fits in PW bits.
  always_comb begin
    s  = '0;
    c  = '0;
    pp = '0;
    ns = '0;
    nc = '0;
    for (int i = 0; i < W; i++) begin
      pp = PW'(a & {W{b[i]}}) << i;
      ns = s ^ c ^ pp;
      nc = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = ns;
      c  = nc;
    end
  end

  // Final carry-propagate add collapses the redundant form
  assign p = s + c;

endmodule

// File: rtl/mult6_rr_scheduler.sv
// Round-robin scheduler sharing one carry-save multiplier among NREQ requesters.
// Latency: accept in cycle T -> rsp_valid in T+2; at most one accept every 3 cycles.
// Backpressure: rsp_ready low holds the response and blocks all grants; MULT_BUSY_CNT_EN adds busy_cycles.
module mult6_rr_scheduler
  import mult6_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_product
`ifdef MULT_BUSY_CNT_EN
  ,
  output logic [15:0]       busy_cycles
`endif
);

  localparam int PW = prod_w(W);

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_vld;
  logic           accept;
  int             scan;

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IDW-1:0] id_q;
  logic [PW-1:0]  core_p;

  // Find the first valid requester at or after the pointer. Scanning from the
  // far end lets the nearest candidate overwrite the others.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = int'(ptr_q) + k;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      if (req_valid[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(scan);
      end
    end
  end

  // Pointer moves to the slot just after the winner, wrapping at NREQ-1
  always_comb begin
    ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  // Next-state and grant decode; grants are suppressed while reset is asserted
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = CALC;
        end
      end
      CALC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's operands and ID, and advance the pointer on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
    end else if (accept) begin
      ptr_q <= ptr_nxt;
      a_q   <= req_a[int'(gnt_idx) * W +: W];
      b_q   <= req_b[int'(gnt_idx) * W +: W];
      id_q  <= gnt_idx;
    end
  end

  mult6_csa_core #(
    .W (W)
  ) u_core (
    .a (a_q),
    .b (b_q),
    .p (core_p)
  );

  // Register the product and tag in CALC; held untouched through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_product <= '0;
      rsp_id      <= '0;
    end else if (state_q == CALC) begin
      rsp_product <= core_p;
      rsp_id      <= id_q;
    end
  end

  assign rsp_valid = (state_q == RESP);

`ifdef MULT_BUSY_CNT_EN
  logic [15:0] busy_cnt;

  // Count non-idle cycles, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if ((state_q != IDLE) && (busy_cnt != 16'hFFFF)) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

  assign busy_cycles = busy_cnt;
`endif

endmodule
